// File: rtl/aes_core_arbiter_if.sv
// Bundle of the two requester channels and the AES engine hookup shared by the arbiter.
// The arbiter takes the slave view; requesters and engine together form the master view.
interface aes_core_arbiter_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         resp0_valid;
  logic         resp0_ready;
  logic [127:0] resp0_data;
  logic         resp0_err;

  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic         resp1_valid;
  logic         resp1_ready;
  logic [127:0] resp1_data;
  logic         resp1_err;

  logic         core_rst_n;
  logic [127:0] core_data_in;
  logic [127:0] core_key;
  logic [127:0] core_data_out;
  logic         core_finished;
  logic         busy;

  modport slave (
    input  req0_valid, req0_data, req0_key, resp0_ready,
    input  req1_valid, req1_data, req1_key, resp1_ready,
    input  core_data_out, core_finished,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err,
    output core_rst_n, core_data_in, core_key, busy
  );

  modport master (
    output req0_valid, req0_data, req0_key, resp0_ready,
    output req1_valid, req1_data, req1_key, resp1_ready,
    output core_data_out, core_finished,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err,
    input  core_rst_n, core_data_in, core_key, busy
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin front end sharing one AES engine between two requesters; the engine is
// restarted through its reset for every operation and guarded by a run watchdog.
module aes_core_arbiter #(
  parameter int RST_PULSE      = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic              clk,
  input logic              rst_n,
  aes_core_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic             r_lastGrant;
  logic             r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_coreRstN;
  logic             r_busy;
  logic [127:0]     r_dataIn;
  logic [127:0]     r_keyIn;
  logic             r_resp0Valid;
  logic [127:0]     r_resp0Data;
  logic             r_resp0Err;
  logic             r_resp1Valid;
  logic [127:0]     r_resp1Data;
  logic             r_resp1Err;

  logic w_grant0;
  logic w_grant1;
  logic w_ready0;
  logic w_ready1;
  logic w_respDone;
  logic w_runEnd;

  // Ready is gated by rst_n so no grant is advertised while the block is held in reset.
  always_comb begin
    w_grant0   = arb.req0_valid && (!arb.req1_valid || r_lastGrant);
    w_grant1   = arb.req1_valid && (!arb.req0_valid || !r_lastGrant);
    w_ready0   = rst_n && (r_state == IDLE) && w_grant0;
    w_ready1   = rst_n && (r_state == IDLE) && w_grant1;
    w_respDone = (!r_grant && r_resp0Valid && arb.resp0_ready) ||
                 ( r_grant && r_resp1Valid && arb.resp1_ready);
    w_runEnd   = arb.core_finished || (r_cnt == RUN_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lastGrant  <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_coreRstN   <= 1'b0;
      r_busy       <= 1'b0;
      r_dataIn     <= '0;
      r_keyIn      <= '0;
      r_resp0Valid <= 1'b0;
      r_resp0Data  <= '0;
      r_resp0Err   <= 1'b0;
      r_resp1Valid <= 1'b0;
      r_resp1Data  <= '0;
      r_resp1Err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ready0 || w_ready1) begin
            r_dataIn    <= w_ready1 ? arb.req1_data : arb.req0_data;
            r_keyIn     <= w_ready1 ? arb.req1_key  : arb.req0_key;
            r_grant     <= w_ready1;
            r_lastGrant <= w_ready1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= LOAD;
          end
        end

        LOAD: begin
          if (r_cnt == LOAD_LAST) begin
            r_cnt      <= '0;
            r_coreRstN <= 1'b1;
            r_state    <= RUN;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // A finished flag in the watchdog's last cycle still counts as success.
        RUN: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_runEnd) begin
            r_coreRstN <= 1'b0;
            r_state    <= RESP;
            if (r_grant) begin
              r_resp1Valid <= 1'b1;
              r_resp1Data  <= arb.core_finished ? arb.core_data_out : '0;
              r_resp1Err   <= !arb.core_finished;
            end else begin
              r_resp0Valid <= 1'b1;
              r_resp0Data  <= arb.core_finished ? arb.core_data_out : '0;
              r_resp0Err   <= !arb.core_finished;
            end
          end
        end

        RESP: begin
          if (w_respDone) begin
            r_resp0Valid <= 1'b0;
            r_resp1Valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign arb.req0_ready   = w_ready0;
  assign arb.req1_ready   = w_ready1;
  assign arb.resp0_valid  = r_resp0Valid;
  assign arb.resp0_data   = r_resp0Data;
  assign arb.resp0_err    = r_resp0Err;
  assign arb.resp1_valid  = r_resp1Valid;
  assign arb.resp1_data   = r_resp1Data;
  assign arb.resp1_err    = r_resp1Err;
  assign arb.core_rst_n   = r_coreRstN;
  assign arb.core_data_in = r_dataIn;
  assign arb.core_key     = r_keyIn;
  assign arb.busy         = r_busy;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration, latency and results.
module tb_aes_core_arbiter;

  localparam int RST_PULSE      = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_W          = 8;

  localparam logic [127:0] VEC_DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;

  aes_core_arbiter_if bus ();

  aes_core_arbiter #(
    .RST_PULSE      (RST_PULSE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Engine stand-in: finishes during its engLat-th cycle out of reset (0 = never).
  int runCnt = 0;
  int engLat = 0;

  logic [127:0] reqData [2];
  logic [127:0] reqKey  [2];
  int           modelLast;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!bus.core_rst_n) runCnt <= 0;
    else                 runCnt <= runCnt + 1;
  end

  // Known FIPS-197 vector gives the real ciphertext; anything else gets a cheap mix.
  function automatic logic [127:0] engineFn(input logic [127:0] d, input logic [127:0] k);
    if (d == VEC_DATA && k == VEC_KEY) return VEC_CT;
    return {d[119:0], d[127:120]} ^ k ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
  endfunction

  assign bus.core_data_out = engineFn(bus.core_data_in, bus.core_key);
  assign bus.core_finished = bus.core_rst_n && (engLat != 0) && (runCnt >= engLat - 1);

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic getReady(input int ch);
    return (ch == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic getRespValid(input int ch);
    return (ch == 1) ? bus.resp1_valid : bus.resp0_valid;
  endfunction

  function automatic logic [127:0] getRespData(input int ch);
    return (ch == 1) ? bus.resp1_data : bus.resp0_data;
  endfunction

  function automatic logic getRespErr(input int ch);
    return (ch == 1) ? bus.resp1_err : bus.resp0_err;
  endfunction

  task automatic setValid(input int ch, input logic v);
    if (ch == 1) bus.req1_valid = v;
    else         bus.req0_valid = v;
  endtask

  task automatic setRespReady(input int ch, input logic v);
    if (ch == 1) bus.resp1_ready = v;
    else         bus.resp0_ready = v;
  endtask

  // Raises a request on channel ch with the given payload.
  task automatic applyStimulus(input int ch, input logic [127:0] d, input logic [127:0] k);
    reqData[ch] = d;
    reqKey[ch]  = k;
    if (ch == 1) begin
      bus.req1_data = d;
      bus.req1_key  = k;
    end else begin
      bus.req0_data = d;
      bus.req0_key  = k;
    end
    setValid(ch, 1'b1);
  endtask

  // Called at a negedge; returns once ready on ch has been seen (handshake at the next posedge).
  task automatic waitGrant(input int ch, output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (getReady(ch)) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!ok) checkOutput("grantTimeout", 0, 1);
    else     checkOutput("otherReadyLow", getReady(1 - ch), 0);
  endtask

  // Runs one complete transaction on ch and checks it against the model.
  task automatic serveOne(input int ch, input int lat, input int holdCycles, output int waited);
    bit           ok;
    int           hsCyc;
    int           k;
    logic [127:0] expData;
    logic         expErr;

    engLat = lat;
    waitGrant(ch, waited, ok);
    if (!ok) return;
    hsCyc = cyc;
    @(negedge clk);
    setValid(ch, 1'b0);

    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (getRespValid(ch)) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checkOutput("respTimeout", 0, 1);
      return;
    end

    if (lat == 0 || lat > TIMEOUT_CYCLES) begin
      k       = TIMEOUT_CYCLES;
      expData = '0;
      expErr  = 1'b1;
    end else begin
      k       = lat;
      expData = engineFn(reqData[ch], reqKey[ch]);
      expErr  = 1'b0;
    end

    checkOutput("latency", 128'(cyc - hsCyc), 128'(RST_PULSE + k + 1));
    checkOutput("respData", getRespData(ch), expData);
    checkOutput("respErr", getRespErr(ch), expErr);
    checkOutput("otherRespLow", getRespValid(1 - ch), 0);
    checkOutput("busyInResp", bus.busy, 1);
    checkOutput("coreRstInResp", bus.core_rst_n, 0);
    checkOutput("coreDataHeld", bus.core_data_in, reqData[ch]);
    checkOutput("coreKeyHeld", bus.core_key, reqKey[ch]);

    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      #1;
      checkOutput("holdValid", getRespValid(ch), 1);
      checkOutput("holdData", getRespData(ch), expData);
      checkOutput("holdErr", getRespErr(ch), expErr);
      checkOutput("stallReady", getReady(1 - ch), 0);
    end

    setRespReady(ch, 1'b1);
    @(negedge clk);
    setRespReady(ch, 1'b0);
    checkOutput("respDropped", getRespValid(ch), 0);
    checkOutput("busyAfterResp", bus.busy, 0);
  endtask

  task automatic servePair(input int lat0, input int lat1);
    int first;
    int w;
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    applyStimulus(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    first = (modelLast == 1) ? 0 : 1;
    serveOne(first, (first == 0) ? lat0 : lat1, $urandom_range(0, 3), w);
    checkOutput("pairFirstImmediate", 128'(w), 0);
    modelLast = first;
    serveOne(1 - first, (first == 0) ? lat1 : lat0, $urandom_range(0, 3), w);
    checkOutput("pairSecondImmediate", 128'(w), 0);
    modelLast = 1 - first;
  endtask

  function automatic int randLat();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return 0;
    if (sel < 3)  return int'($urandom_range(TIMEOUT_CYCLES - 2, TIMEOUT_CYCLES + 2));
    return int'($urandom_range(1, 20));
  endfunction

  initial begin
    int  w;
    bit  ok;
    int  pattern;

    rst_n           = 1'b0;
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.req0_data   = '0;
    bus.req0_key    = '0;
    bus.req1_data   = '0;
    bus.req1_key    = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    modelLast       = 1;

    // Reset values, including no ready advertised while in reset.
    repeat (3) @(negedge clk);
    bus.req0_valid = 1'b1;
    #1;
    checkOutput("rstReady0", bus.req0_ready, 0);
    checkOutput("rstReady1", bus.req1_ready, 0);
    checkOutput("rstResp0Valid", bus.resp0_valid, 0);
    checkOutput("rstResp1Valid", bus.resp1_valid, 0);
    checkOutput("rstResp0Err", bus.resp0_err, 0);
    checkOutput("rstResp1Err", bus.resp1_err, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstCoreRst", bus.core_rst_n, 0);
    checkOutput("rstCoreData", bus.core_data_in, 0);
    checkOutput("rstCoreKey", bus.core_key, 0);
    checkOutput("rstResp0Data", bus.resp0_data, 0);
    checkOutput("rstResp1Data", bus.resp1_data, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single request with FIPS-197 vector");
    applyStimulus(0, VEC_DATA, VEC_KEY);
    serveOne(0, 11, 0, w);
    modelLast = 0;
    checkOutput("vectorResult", bus.resp0_data, VEC_CT);

    $display("[TB] simultaneous pairs alternate");
    servePair(5, 7);
    servePair(3, 4);

    $display("[TB] watchdog expiry");
    applyStimulus(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    serveOne(1, 0, 2, w);
    modelLast = 1;

    $display("[TB] response backpressure with competing request");
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    applyStimulus(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    serveOne(0, 6, 10, w);
    modelLast = 0;
    serveOne(1, 6, 0, w);
    checkOutput("grantAfterResp", 128'(w), 0);
    modelLast = 1;

    $display("[TB] finished and watchdog in the same cycle");
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    serveOne(0, TIMEOUT_CYCLES, 1, w);
    modelLast = 0;
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    serveOne(0, TIMEOUT_CYCLES + 1, 0, w);

    $display("[TB] asynchronous reset during RUN");
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    engLat = 0;
    waitGrant(0, w, ok);
    @(negedge clk);
    setValid(0, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("runBeforeReset", bus.core_rst_n, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstCoreRst", bus.core_rst_n, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstResp0", bus.resp0_valid, 0);
    checkOutput("midRstResp1", bus.resp1_valid, 0);
    checkOutput("midRstCoreData", bus.core_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("noRespAfterRst0", bus.resp0_valid, 0);
    checkOutput("noRespAfterRst1", bus.resp1_valid, 0);
    modelLast = 1;
    servePair(4, 9);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 30; n++) begin
      pattern = int'($urandom_range(0, 2));
      if (pattern == 2) begin
        servePair(randLat(), randLat());
      end else begin
        applyStimulus(pattern, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});
        serveOne(pattern, randLat(), int'($urandom_range(0, 4)), w);
        checkOutput("soloImmediate", 128'(w), 0);
        modelLast = pattern;
      end
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Front-end controller that shares one AES engine (cipher or decipher build, selected at compile time) between two requesters.
- Each requester uses a valid/ready request channel carrying 128-bit data and a 128-bit key, and a valid/ready response channel returning the 128-bit result.
- The controller arbitrates round-robin, latches the operands, restarts the engine through its reset input, waits for the engine's finished flag (with a watchdog), and routes the result back to the winning requester.

Parameters:
- RST_PULSE, 2, cycles core_rst_n is held low after a grant before the engine runs (min 1).
- TIMEOUT_CYCLES, 64, max RUN cycles without core_finished before an error response (min 2).
- CNT_W, 8, width of the shared pulse/watchdog counter; must hold max(RST_PULSE, TIMEOUT_CYCLES).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_data  in  128  plaintext (cipher build) or ciphertext (decipher build).
- req0_key  in  128  cipher key or round-10 key.
- resp0_valid  out  1  result for requester 0 is available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_data  out  128  result.
- resp0_err  out  1  watchdog expired; resp0_data is 0.
- req1_valid, req1_ready, req1_data, req1_key, resp1_valid, resp1_ready, resp1_data, resp1_err: same as channel 0, for requester 1.
- core_rst_n  out  1  drives engine rst_n.
- core_data_in  out  128  latched data to engine.
- core_key  out  128  latched key to engine.
- core_data_out  in  128  engine result.
- core_finished  in  1  engine done flag (level).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - all valid/ready/err outputs 0; busy 0.
  - core_rst_n 0.
  - core_data_in, core_key, resp*_data all 0.
  - state IDLE; last_grant 1, so channel 0 wins the first tie.
- FSM states: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - core_rst_n = 0 (engine parked in reset).
  - reqN_ready is combinational and high only for the granted channel.
  - Grant rule: if only one req_valid is high, grant it. If both are high, grant the channel != last_grant.
  - On handshake: latch data/key into core_data_in/core_key, record the grant, update last_grant, clear the counter, go to LOAD.
- LOAD:
  - core_rst_n = 0; counter increments.
  - After RST_PULSE cycles go to RUN and clear the counter.
- RUN:
  - core_rst_n = 1; counter increments each cycle.
  - If core_finished = 1: capture core_data_out into the granted channel's resp_data, err = 0, go to RESP.
  - Else if counter reaches TIMEOUT_CYCLES-1: resp_data = 0, err = 1, go to RESP.
  - If finished and timeout occur in the same cycle, finished wins.
- RESP:
  - core_rst_n = 0.
  - Only the granted channel's resp_valid is high; data and err are held stable.
  - On resp_valid && resp_ready, drop resp_valid and go to IDLE.
  - req_ready is 0 in every non-IDLE state, so new requests stall.
- Latency and throughput:
  - Request handshake to resp_valid = RST_PULSE + engine_cycles + 1 clocks, where engine_cycles counts RUN cycles up to and including the one with core_finished high.
  - Back-to-back requests are separated by at least one IDLE cycle.
- Stability: core_data_in and core_key stay constant from LOAD through RESP; they change only on an IDLE handshake.
- Asynchronous reset mid-operation: immediately returns to the reset values. Any in-flight operation is dropped with no response, and last_grant returns to 1.
- A requester may deassert req_valid before it is granted. Its payload is not sampled unless the handshake occurs.

Test Plan:
- Single request, cipher build. Engine model asserts finished 11 cycles after core_rst_n rises. req0: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> resp0_valid 14 cycles after handshake (RST_PULSE=2), resp0_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp0_err 0.
- req0 and req1 valid in the same IDLE cycle after reset -> ch0 is served first, then ch1. A second simultaneous pair is served ch0 then ch1 again, confirming alternation.
- Engine model never asserts finished -> resp_err 1 and resp_data 0 after 2 + 64 + 1 cycles; busy deasserts after resp_ready.
- Hold resp0_ready low for 10 cycles while req1_valid is high -> resp0 data stays stable, req1_ready stays 0, and req1 is granted the cycle after the resp0 handshake.
- Assert rst_n low during RUN -> core_rst_n, busy and all valids go to 0 immediately with no response. A following request completes normally with ch0 priority.
- core_finished and the timeout hit in the same cycle -> resp_err 0, and resp_data equals core_data_out.
